// File: rtl/truth_table_sweeper_if.sv
// truth_table_sweeper_if
// Row stream carrying one captured truth-table row per transfer.
//   row_valid  master->slave  row_in/row_out hold a captured row
//   row_ready  slave->master  consumer accepts the row this cycle
//   row_in     master->slave  input vector of the row (IN_W bits)
//   row_out    master->slave  sampled DUT response (OUT_W bits)
interface truth_table_sweeper_if #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 2
);
  logic             row_valid;
  logic             row_ready;
  logic [IN_W-1:0]  row_in;
  logic [OUT_W-1:0] row_out;

  modport master (output row_valid, output row_in, output row_out, input row_ready);
  modport slave  (input row_valid, input row_in, input row_out, output row_ready);
endinterface

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
// Self-running stimulus/capture engine. It walks every IN_W-bit input vector
// and holds each vector SETTLE cycles. It then samples the DUT response and
// streams the (input, output) row out. Each accepted row is folded into a
// rotate-xor signature.
// Optional feature: define TT_SWEEP_GRAY_EN to sweep in Gray-code order
// (one DUT input toggles between rows); otherwise binary order.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start          one-cycle sweep request (ignored while busy)
//   dut_in         vector driven to the DUT
//   dut_out        DUT response
//   row            row stream (master side of truth_table_sweeper_if)
//   busy           sweep in progress
//   done           sweep complete, held until next start
//   signature      running/final signature
//   expected_sig   reference signature
//   pass           done & (signature == expected_sig)
module truth_table_sweeper #(
  parameter int IN_W   = 3,
  parameter int OUT_W  = 2,
  parameter int SETTLE = 2,
  parameter int SIG_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic [IN_W-1:0]        dut_in,
  input  logic [OUT_W-1:0]       dut_out,
  truth_table_sweeper_if.master  row,
  output logic                   busy,
  output logic                   done,
  output logic [SIG_W-1:0]       signature,
  input  logic [SIG_W-1:0]       expected_sig,
  output logic                   pass
);

  localparam int CNT_W = $clog2(SETTLE + 1);
  localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);
  // idx carries one extra bit so the last-row compare never aliases on wrap.
  localparam logic [IN_W:0] LAST_IDX = {1'b0, {IN_W{1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_EMIT, S_DONE} state_t;

  state_t            state;
  logic [IN_W:0]     idx;
  logic [IN_W:0]     idx_next;
  logic [CNT_W-1:0]  cnt;
  logic [SIG_W-1:0]  row_word;
  logic [SIG_W-1:0]  next_sig;

  function automatic logic [IN_W-1:0] vec(input logic [IN_W:0] i);
`ifdef TT_SWEEP_GRAY_EN
    vec = i[IN_W-1:0] ^ (i[IN_W-1:0] >> 1);
`else
    vec = i[IN_W-1:0];
`endif
  endfunction

  assign idx_next = idx + (IN_W+1)'(1);

  // Current row zero-extended to the signature width, then folded in
  // with a rotate-left-by-one so the signature depends on row order.
  always_comb begin
    row_word = '0;
    row_word[IN_W+OUT_W-1:0] = {row.row_in, row.row_out};
    next_sig = {signature[SIG_W-2:0], signature[SIG_W-1]} ^ row_word;
  end

  assign pass = done & (signature == expected_sig);

  // Sweep sequencer: DRIVE holds a vector for SETTLE cycles and samples on
  // the last one, and EMIT presents the row until it is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      idx           <= '0;
      cnt           <= '0;
      dut_in        <= '0;
      row.row_valid <= 1'b0;
      row.row_in    <= '0;
      row.row_out   <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      signature     <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            idx       <= '0;
            signature <= '0;
            done      <= 1'b0;
            busy      <= 1'b1;
            cnt       <= SETTLE_C;
            dut_in    <= vec('0);
            state     <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            row.row_in    <= dut_in;
            row.row_out   <= dut_out;
            row.row_valid <= 1'b1;
            state         <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (row.row_ready) begin
            signature     <= next_sig;
            row.row_valid <= 1'b0;
            if (idx == LAST_IDX) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
            end else begin
              idx    <= idx_next;
              dut_in <= vec(idx_next);
              cnt    <= SETTLE_C;
              state  <= S_DRIVE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper
// Directed bench for truth_table_sweeper with IN_W=3, OUT_W=2, SETTLE=2.
// Expected row order and signature follow TT_SWEEP_GRAY_EN when it is defined.
module tb_truth_table_sweeper;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  dut_in;
  logic [1:0]  dut_out;
  logic        busy;
  logic        done;
  logic [15:0] signature;
  logic [15:0] expected_sig;
  logic        pass;
  logic        model_mode;

  int total;
  int bad;

  truth_table_sweeper_if #(.IN_W(3), .OUT_W(2)) row_if ();

  truth_table_sweeper #(.IN_W(3), .OUT_W(2), .SETTLE(2), .SIG_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .dut_in       (dut_in),
    .dut_out      (dut_out),
    .row          (row_if),
    .busy         (busy),
    .done         (done),
    .signature    (signature),
    .expected_sig (expected_sig),
    .pass         (pass)
  );

  // Lab DUT: X = A&B, Y = A^B^C with A=bit2, B=bit1, C=bit0; tied 0 otherwise.
  assign dut_out = model_mode ? {dut_in[2] & dut_in[1], dut_in[2] ^ dut_in[1] ^ dut_in[0]} : 2'b00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef TT_SWEEP_GRAY_EN
  logic [2:0]  exp_in [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
  logic [15:0] exp_sig = 16'h0088;
`else
  logic [2:0]  exp_in [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [15:0] exp_sig = 16'h003C;
`endif
  // {X,Y} indexed by input vector, worked out by hand.
  logic [1:0] tt [8] = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd1, 2'd0, 2'd2, 2'd3};

  logic [2:0] got_in  [16];
  logic [1:0] got_out [16];

  // Pulses start, records rows with ready held high, and returns the number
  // of cycles from the start edge to done (capped at 200 on a hang).
  task automatic run_sweep(input int inject_k, output int cycles, output int nrows,
                           output logic busy0);
    int k;
    nrows = 0;
    k = 0;
    row_if.row_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy0 = busy;
    while (!done && k < 200) begin
      if (row_if.row_valid && nrows < 16) begin
        got_in[nrows]  = row_if.row_in;
        got_out[nrows] = row_if.row_out;
        nrows++;
      end
      start = (k == inject_k);
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    cycles = k;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (dut_in !== 3'd0) begin bad++; $display("[TB] FAIL rst_dut_in got=%0d want=0", dut_in); end
    total++; if (row_if.row_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_row_valid got=%b want=0", row_if.row_valid); end
    total++; if (row_if.row_in !== 3'd0) begin bad++; $display("[TB] FAIL rst_row_in got=%0d want=0", row_if.row_in); end
    total++; if (row_if.row_out !== 2'd0) begin bad++; $display("[TB] FAIL rst_row_out got=%0d want=0", row_if.row_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL rst_done got=%b want=0", done); end
    total++; if (signature !== 16'h0) begin bad++; $display("[TB] FAIL rst_signature got=%h want=0000", signature); end
    total++; if (pass !== 1'b0) begin bad++; $display("[TB] FAIL rst_pass got=%b want=0", pass); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sweep;
    int cycles, nrows;
    logic busy0;
    model_mode = 1'b0;
    run_sweep(-1, cycles, nrows, busy0);
    total++; if (busy0 !== 1'b1) begin bad++; $display("[TB] FAIL sweep_busy_rise got=%b want=1", busy0); end
    total++; if (cycles != 24) begin bad++; $display("[TB] FAIL sweep_cycles got=%0d want=24", cycles); end
    total++; if (nrows != 8) begin bad++; $display("[TB] FAIL sweep_rows got=%0d want=8", nrows); end
    for (int i = 0; i < 8 && i < nrows; i++) begin
      total++;
      if (got_in[i] !== exp_in[i] || got_out[i] !== 2'd0) begin
        bad++;
        $display("[TB] FAIL sweep_row%0d got=%0d/%0d want=%0d/0", i, got_in[i], got_out[i], exp_in[i]);
      end
    end
    total++; if (signature !== exp_sig) begin bad++; $display("[TB] FAIL sweep_sig got=%h want=%h", signature, exp_sig); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL sweep_busy_end got=%b want=0", busy); end
    expected_sig = exp_sig;
    #1;
    total++; if (pass !== 1'b1) begin bad++; $display("[TB] FAIL pass_match got=%b want=1", pass); end
    expected_sig = exp_sig + 16'h1;
    #1;
    total++; if (pass !== 1'b0) begin bad++; $display("[TB] FAIL pass_mismatch got=%b want=0", pass); end
    expected_sig = exp_sig;
    @(negedge clk);
  endtask

  task automatic test_dut_model;
    int cycles, nrows;
    logic busy0;
    model_mode = 1'b1;
    run_sweep(-1, cycles, nrows, busy0);
    total++; if (nrows != 8) begin bad++; $display("[TB] FAIL model_rows got=%0d want=8", nrows); end
    for (int i = 0; i < 8 && i < nrows; i++) begin
      total++;
      if (got_in[i] !== exp_in[i] || got_out[i] !== tt[exp_in[i]]) begin
        bad++;
        $display("[TB] FAIL model_row%0d got=%0d/%0d want=%0d/%0d", i, got_in[i], got_out[i], exp_in[i], tt[exp_in[i]]);
      end
    end
    model_mode = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int k, n;
    logic hold;
    logic [2:0] held_in;
    logic [1:0] held_out;
    logic r;
    k = 0; n = 0; hold = 1'b0; held_in = '0; held_out = '0;
    model_mode = 1'b0;
    row_if.row_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (k < 400) begin
      if (hold) begin
        total++;
        if (row_if.row_valid !== 1'b1 || row_if.row_in !== held_in || row_if.row_out !== held_out) begin
          bad++;
          $display("[TB] FAIL bp_hold got=%b/%0d/%0d want=1/%0d/%0d",
                   row_if.row_valid, row_if.row_in, row_if.row_out, held_in, held_out);
        end
      end
      r = 1'($urandom_range(0, 1));
      row_if.row_ready = r;
      if (row_if.row_valid) begin
        hold = !r;
        held_in = row_if.row_in;
        held_out = row_if.row_out;
        if (r && n < 16) begin
          got_in[n] = row_if.row_in;
          got_out[n] = row_if.row_out;
          n++;
        end
      end else begin
        hold = 1'b0;
      end
      if (done) break;
      @(negedge clk);
      k++;
    end
    row_if.row_ready = 1'b1;
    total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL bp_done got=%b want=1", done); end
    total++; if (n != 8) begin bad++; $display("[TB] FAIL bp_rows got=%0d want=8", n); end
    for (int i = 0; i < 8 && i < n; i++) begin
      total++;
      if (got_in[i] !== exp_in[i] || got_out[i] !== 2'd0) begin
        bad++;
        $display("[TB] FAIL bp_row%0d got=%0d/%0d want=%0d/0", i, got_in[i], got_out[i], exp_in[i]);
      end
    end
    total++; if (signature !== exp_sig) begin bad++; $display("[TB] FAIL bp_sig got=%h want=%h", signature, exp_sig); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_sweep;
    int k, cycles, nrows;
    logic busy0;
    k = 0;
    row_if.row_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!(busy && dut_in == exp_in[4]) && k < 100) begin
      @(negedge clk);
      k++;
    end
    total++; if (k >= 100) begin bad++; $display("[TB] FAIL midrst_reach_row4 got=timeout want=row4"); end
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || done !== 1'b0 || row_if.row_valid !== 1'b0)
      begin bad++; $display("[TB] FAIL midrst_ctrl got=%b%b%b want=000", busy, done, row_if.row_valid); end
    total++; if (dut_in !== 3'd0 || row_if.row_in !== 3'd0 || row_if.row_out !== 2'd0)
      begin bad++; $display("[TB] FAIL midrst_data got=%0d/%0d/%0d want=0/0/0", dut_in, row_if.row_in, row_if.row_out); end
    total++; if (signature !== 16'h0 || pass !== 1'b0)
      begin bad++; $display("[TB] FAIL midrst_sig got=%h/%b want=0000/0", signature, pass); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_sweep(-1, cycles, nrows, busy0);
    total++; if (cycles != 24 || nrows != 8) begin bad++; $display("[TB] FAIL midrst_resweep got=%0d/%0d want=24/8", cycles, nrows); end
    total++; if (signature !== exp_sig) begin bad++; $display("[TB] FAIL midrst_sig_after got=%h want=%h", signature, exp_sig); end
  endtask

  task automatic test_start_while_busy;
    int cycles, nrows;
    logic busy0;
    run_sweep(5, cycles, nrows, busy0);
    total++; if (cycles != 24) begin bad++; $display("[TB] FAIL busy_start_cycles got=%0d want=24", cycles); end
    total++; if (signature !== exp_sig) begin bad++; $display("[TB] FAIL busy_start_sig got=%h want=%h", signature, exp_sig); end
  endtask

  task automatic test_restart_from_done;
    int cycles, nrows;
    logic busy0;
    total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL restart_pre_done got=%b want=1", done); end
    run_sweep(-1, cycles, nrows, busy0);
    total++; if (busy0 !== 1'b1) begin bad++; $display("[TB] FAIL restart_busy got=%b want=1", busy0); end
    total++; if (cycles != 24) begin bad++; $display("[TB] FAIL restart_cycles got=%0d want=24", cycles); end
    total++; if (signature !== exp_sig) begin bad++; $display("[TB] FAIL restart_sig got=%h want=%h", signature, exp_sig); end
  endtask

  // Done must clear on the first cycle after a start taken from DONE.
  task automatic test_done_clear;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL done_clear got=%b want=0", done); end
    repeat (30) @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    start = 1'b0;
    model_mode = 1'b0;
    expected_sig = 16'h0;
    row_if.row_ready = 1'b1;
    test_reset();
    test_sweep();
    test_dut_model();
    test_backpressure();
    test_reset_mid_sweep();
    test_start_while_busy();
    test_restart_from_done();
    test_done_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Parametrised, self-running stimulus and capture engine for combinational lab blocks. It drives every input combination of an IN_W-bit device under test and waits a programmable settle time. It then samples the DUT's OUT_W-bit response, streams each (input, output) row out over a valid/ready port, and folds it into a running signature compared against an expected value. It replaces hand-written per-lab stimulus blocks with one reusable sequencer in front of any small combinational module.

## Interface
- IN_W, 3, DUT input width (1..8)
- OUT_W, 2, DUT output width (1..8); IN_W+OUT_W ≤ SIG_W
- SETTLE, 2, cycles each vector is held before sampling (≥1)
- SIG_W, 16, signature width
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request to begin a sweep
- dut_in  out  IN_W  vector driven to DUT
- dut_out  in  OUT_W  DUT response
- row_valid  out  1  captured row available
- row_ready  in  1  consumer accepts row
- row_in  out  IN_W  input vector of current row
- row_out  out  OUT_W  sampled response of current row
- busy  out  1  sweep in progress
- done  out  1  sweep complete, held until next start
- signature  out  SIG_W  running/final signature
- expected_sig  in  SIG_W  reference signature
- pass  out  1  done & (signature == expected_sig), combinational

## Operation
- States: IDLE, DRIVE, EMIT, DONE.
- IDLE/DONE + start: idx←0, signature←0, done←0, settle counter←SETTLE, dut_in←vec(0), go DRIVE.
- start in DRIVE/EMIT ignored.
- DRIVE: counter decrements each cycle. On the cycle it reads 1: row_out←dut_out, row_in←dut_in, go EMIT.
- EMIT: row_valid=1. row_in/row_out are stable until the row is accepted.
- EMIT + row_ready: signature←rotl(signature,1) ^ zero_ext({row_in,row_out}).
  - idx = 2^IN_W−1: go DONE.
  - Otherwise: idx←idx+1, dut_in←vec(idx+1), counter←SETTLE, go DRIVE.
- DONE: done=1, busy=0, signature frozen.
- vec(i) = i; see Configuration.
- idx is IN_W+1 bits wide so the last-row test never aliases on wrap.
- busy=1 in DRIVE and EMIT only.

## Timing
- Reset values: dut_in=0, row_valid=0, row_in=0, row_out=0, busy=0, done=0, signature=0, pass=0; state IDLE.
- busy rises the cycle after start is sampled.
- Row cost: SETTLE cycles in DRIVE plus ≥1 cycle in EMIT.
- With row_ready held high, done rises 2^IN_W·(SETTLE+1) cycles after the start edge.
- Backpressure: each cycle row_ready=0 in EMIT adds one cycle; no row is lost or duplicated.
- row_valid is asserted from the cycle after sampling. It never drops without acceptance, except on reset.
- rst_n low mid-sweep: immediate return to the reset values, no row emitted, signature cleared.
- pass tracks expected_sig combinationally while done=1.

## Configuration
- TT_SWEEP_GRAY_EN defined: vec(i) = i ^ (i>>1) (Gray order), so exactly one DUT input toggles between rows. Useful for hazard/glitch labs.
- Undefined: vec(i) = i (binary order).
- The final vector is vec(2^IN_W−1) in both cases. Signature depends on order.

## Test plan
- Binary order, IN_W=3, OUT_W=2, SETTLE=2, dut_out tied 0, row_ready=1, start pulse -> rows 0..7 in order, done after exactly 24 cycles, signature=0x003C, pass=1 with expected_sig=0x003C and pass=0 with 0x003D.
- Same setup with TT_SWEEP_GRAY_EN -> dut_in sequence 0,1,3,2,6,7,5,4; signature=0x0088.
- DUT model X=A&B, Y=A^B^C (A=bit2, B=bit1, C=bit0), binary order -> the 8 emitted row_out values match the truth table row for row.
- row_ready toggled pseudo-randomly -> the same 8 rows and same signature as the ready-high run, with each row held stable while row_valid=1 and row_ready=0.
- rst_n pulsed low during row 4 -> all outputs at reset values the same cycle. A new start gives a full clean sweep with the unchanged final signature.
- start reasserted while busy -> ignored, sweep length unchanged. start while done=1 -> done clears next cycle and a new sweep begins.
